// File: rtl/i2c_axil_regs.sv
// AXI4-Lite register bank in front of the I2C master core: CMD/WDATA/RDATA/STATUS plus launch/timeout tracking.
// Optional: define I2C_IRQ_EN to add irq_o and the STATUS[8] interrupt enable.
module i2c_axil_regs #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       cmd_o,
    output logic [31:0]       wdata_o,
    input  logic [31:0]       rdata_i,
    input  logic              busy_i,
    input  logic              done_i
`ifdef I2C_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_WDATA  = 2'd1;
    localparam logic [1:0] REG_RDATA  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_RUN} state_t;

    state_t            state, state_nx;
    logic              live;
    logic              aw_held, w_held;
    logic [1:0]        aw_sel;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic [31:0]       rdata_q;
    logic              done_q, to_q;
    logic [CNT_W-1:0]  cnt;
    logic              irq_en_c;

    logic              wr_fire_c, wr_cmd_c, wr_status_c, cmd_block_c, launch_c;
    logic              active_c, finish_c, tmo_c, pending_c;
    logic [31:0]       cmd_new_c, status_c, rd_mux_c;
    logic              unused_c;

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

    assign unused_c = ^{s_awaddr[1:0], s_araddr[1:0]};

    // Ready outputs stay low while in reset and for the first cycle after it.
    assign s_awready = live && !aw_held && !s_bvalid;
    assign s_wready  = live && !w_held && !s_bvalid;
    assign s_arready = live && !s_rvalid;
    assign s_rresp   = RESP_OKAY;

    assign wr_fire_c   = aw_held && w_held;
    assign wr_cmd_c    = wr_fire_c && (aw_sel == REG_CMD);
    assign wr_status_c = wr_fire_c && (aw_sel == REG_STATUS) && w_strb[0];
    assign pending_c   = (cmd_o != 32'd0);
    assign cmd_block_c = pending_c || busy_i;
    assign cmd_new_c   = apply_strb(cmd_o, w_data, w_strb);
    assign launch_c    = wr_cmd_c && !cmd_block_c && (cmd_new_c != 32'd0);
    assign active_c    = (state != ST_IDLE);
    assign finish_c    = active_c && done_i;
    assign tmo_c       = active_c && !done_i && (cnt == CNT_LAST);

    assign status_c = {23'd0, irq_en_c, 4'd0, pending_c, to_q, done_q, busy_i};

    always_comb begin
        rd_mux_c = status_c;
        case (s_araddr[3:2])
            REG_CMD:   rd_mux_c = cmd_o;
            REG_WDATA: rd_mux_c = wdata_o;
            REG_RDATA: rd_mux_c = rdata_q;
            default:   rd_mux_c = status_c;
        endcase
    end

    // Command FSM next state; a done seen in LAUNCH counts as completion.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (launch_c) state_nx = ST_LAUNCH;
            ST_LAUNCH: begin
                if (done_i || tmo_c) state_nx = ST_IDLE;
                else if (busy_i)     state_nx = ST_RUN;
            end
            ST_RUN:    if (done_i || tmo_c) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Write address/data buffers and response.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            live     <= 1'b0;
            aw_held  <= 1'b0;
            aw_sel   <= 2'd0;
            w_held   <= 1'b0;
            w_data   <= 32'd0;
            w_strb   <= 4'd0;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else begin
            live <= 1'b1;
            if (wr_fire_c) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= (wr_cmd_c && cmd_block_c) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (s_awvalid && s_awready) begin
                    aw_held <= 1'b1;
                    aw_sel  <= s_awaddr[3:2];
                end
                if (s_wvalid && s_wready) begin
                    w_held <= 1'b1;
                    w_data <= s_wdata;
                    w_strb <= s_wstrb;
                end
                if (s_bvalid && s_bready) s_bvalid <= 1'b0;
            end
        end
    end

    // Register file, sticky status (set beats W1C) and timeout counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cmd_o   <= 32'd0;
            wdata_o <= 32'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            cnt     <= '0;
        end else begin
            if (finish_c || tmo_c)             cmd_o <= 32'd0;
            else if (wr_cmd_c && !cmd_block_c) cmd_o <= cmd_new_c;

            if (wr_fire_c && (aw_sel == REG_WDATA)) wdata_o <= apply_strb(wdata_o, w_data, w_strb);

            if (finish_c) rdata_q <= rdata_i;

            if (finish_c)                      done_q <= 1'b1;
            else if (wr_status_c && w_data[1]) done_q <= 1'b0;

            if (tmo_c)                         to_q <= 1'b1;
            else if (wr_status_c && w_data[2]) to_q <= 1'b0;

            if (launch_c)                        cnt <= '0;
            else if (active_c && (cnt != '1))    cnt <= cnt + 1'b1;
        end
    end

`ifdef I2C_IRQ_EN
    logic irq_en_q;

    assign irq_en_c = irq_en_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            irq_en_q <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            if (wr_fire_c && (aw_sel == REG_STATUS) && w_strb[1]) irq_en_q <= w_data[8];
            irq_o <= irq_en_q && (done_q || to_q);
        end
    end
`else
    assign irq_en_c = 1'b0;
`endif

    // Read channel: one-cycle latency, data held until accepted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s_rvalid <= 1'b0;
            s_rdata  <= 32'd0;
        end else if (s_arvalid && s_arready) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_mux_c;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

endmodule

// File: doc/i2c_axil_regs.md
Name: i2c_axil_regs

Overview:
- AXI4-Lite slave register bank directly upstream of the I2C master core.
- Accepts CPU writes of the command word (device/word address, random/page flags) and write data, and drives them to the core's command/data inputs.
- Tracks the transfer through busy/done, captures read data from the core, and exposes status to software.

Parameters:
- ADDR_W, 4, AXI address width; bits [3:2] select the register; bits [1:0] are ignored.
- TIMEOUT_CYC, 65535, max clk cycles busy_i may stay high after launch before abort; 16-bit counter.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- s_awaddr  in  ADDR_W  write address
- s_awvalid/s_awready  in/out  1  AW handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wvalid/s_wready  in/out  1  W handshake
- s_bresp  out  2  write response
- s_bvalid/s_bready  out/in  1  B handshake
- s_araddr  in  ADDR_W  read address
- s_arvalid/s_arready  in/out  1  AR handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid/s_rready  out/in  1  R handshake
- cmd_o  out  32  command word to core (core data0); nonzero = request
- wdata_o  out  32  write payload to core (core data1)
- rdata_i  in  32  read data from core (core mem[2])
- busy_i  in  1  core not idle
- done_i  in  1  one-cycle pulse, core returned to idle

Behaviour:
- Registers: 0x0 CMD (RW), 0x4 WDATA (RW), 0x8 RDATA (RO), 0xC STATUS.
  - STATUS[0] busy (live busy_i), [1] done (sticky, W1C), [2] timeout (sticky, W1C), [3] pending (cmd_o != 0).
- Reset values: all AXI ready/valid outputs 0, bresp/rresp 0, s_rdata 0, cmd_o 0, wdata_o 0, RDATA 0, STATUS sticky bits 0.
- Write channel:
  - AW and W accepted independently; each is latched in a one-entry buffer.
  - s_awready = !aw_held && !s_bvalid; s_wready = !w_held && !s_bvalid.
  - Cycle after both buffers are full: register update is applied, s_bvalid=1, buffers are cleared.
  - s_bvalid holds until s_bready. One outstanding write only.
  - s_wstrb applies per byte to CMD and WDATA.
- Write responses:
  - Write to CMD while pending or busy_i=1: ignored, bresp=SLVERR (2'b10).
  - Write to RDATA: ignored, OKAY.
  - Any write to WDATA: applied, OKAY.
- Read channel:
  - s_arready = !s_rvalid.
  - On AR handshake: s_rdata registered, s_rvalid=1 the next cycle; held stable until s_rready.
  - rresp is always OKAY; 1-cycle latency.
- Command FSM: states IDLE, LAUNCH, RUN.
  - IDLE -> LAUNCH on an accepted nonzero CMD write.
  - LAUNCH -> RUN when busy_i=1.
  - RUN -> IDLE on done_i.
  - On done_i: RDATA <= rdata_i, done<=1, cmd_o<=0 in the same cycle. Clearing cmd_o prevents the core relaunching.
- Timeout:
  - 16-bit counter runs in LAUNCH and RUN; it resets on entry to LAUNCH.
  - Reaching TIMEOUT_CYC: timeout<=1, cmd_o<=0, next state IDLE, RDATA unchanged.
  - The counter saturates; it never wraps.
- Simultaneous events:
  - done_i in the same cycle as a W1C write to done: set wins, done stays 1.
  - done_i in LAUNCH (busy_i missed): treated as RUN completion.
- Reset mid-operation clears everything immediately. The core sees cmd_o=0 on the next sample.

Optional Feature:
- Macro I2C_IRQ_EN.
- Defined:
  - Adds output irq_o (1 bit) and CMD-independent register 0x0 bit... none. Instead STATUS[8] is the irq enable (RW).
  - irq_o = STATUS[8] && (done || timeout), registered, 1 cycle after the sticky bit sets.
  - irq_o clears the cycle after W1C clears both sticky bits.
- Undefined: no irq_o port; STATUS[8] reads 0 and writes to it are ignored.

Test Plan:
- AW sent 3 cycles before W, addr 0x4, data 0xA5A5_1234, strb 4'b0011 -> wdata_o=0x0000_1234, one bvalid, bresp=OKAY.
- Write CMD=0x0000_00A0, core busy_i=1 for 50 cycles then done_i with rdata_i=0xDEAD_BEEF:
  - cmd_o=0xA0 until the done cycle, then 0.
  - Read 0x8 returns 0xDEADBEEF.
  - STATUS=0x2.
- While busy_i=1, write CMD=0x55 -> bresp=SLVERR, cmd_o unchanged.
- TIMEOUT_CYC=20, CMD written, busy_i held 1, no done -> at cycle 20 cmd_o=0, STATUS[2]=1; write 0x4 to STATUS clears it.
- s_rready held low 10 cycles during a read of 0xC -> s_rvalid/s_rdata stable, s_arready=0 throughout.
- I2C_IRQ_EN defined, STATUS[8]=1, transfer completes -> irq_o=1 one cycle after done sets; W1C of done deasserts it.
